// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the 32-bit ALU: captures decoded operands,
// forwards EX/MEM and MEM/WB results onto a/b, and inserts load-use bubbles.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [3:0]  id_aluc,
    input  logic        id_sel_shamt,
    input  logic        id_sel_imm,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    output logic        ex_valid,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [3:0]  ex_aluc,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        load_use_stall
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [3:0]  aluc;
        logic        sel_shamt;
        logic        sel_imm;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic        reg_write;
        logic        mem_read;
    } ex_entry_t;

    typedef enum logic [1:0] {
        UPD_CAPTURE,
        UPD_HOLD,
        UPD_BUBBLE
    } upd_e;

    ex_entry_t   ex_q, ex_d;
    upd_e        upd;
    logic [31:0] fwd_rs, fwd_rt;

    // EX/MEM outranks MEM/WB; register 0 is never a forwarding target.
    function automatic logic [31:0] forward(
        input logic [4:0]  src,
        input logic [31:0] stored,
        input logic        m_we,
        input logic [4:0]  m_rd,
        input logic [31:0] m_res,
        input logic        w_we,
        input logic [4:0]  w_rd,
        input logic [31:0] w_res
    );
        logic [31:0] val;
        val = stored;
        if (m_we && (m_rd != '0) && (m_rd == src)) begin
            val = m_res;
        end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
            val = w_res;
        end
        return val;
    endfunction

    always_comb begin
        fwd_rs = forward(ex_q.rs, ex_q.rs_val, mem_reg_write, mem_rd, mem_result,
                         wb_reg_write, wb_rd, wb_result);
        fwd_rt = forward(ex_q.rt, ex_q.rt_val, mem_reg_write, mem_rd, mem_result,
                         wb_reg_write, wb_rd, wb_result);
    end

    always_comb begin
        load_use_stall = ex_q.valid & ex_q.mem_read & id_valid & (ex_q.rd != '0) &
                         ((ex_q.rd == id_rs) | (ex_q.rd == id_rt));
    end

    always_comb begin
        upd = UPD_CAPTURE;
        if (flush) begin
            upd = UPD_BUBBLE;
        end else if (stall) begin
            upd = UPD_HOLD;
        end else if (load_use_stall) begin
            upd = UPD_BUBBLE;
        end
    end

    // A held entry keeps refreshing its operand values so that a producer
    // retiring while EX is frozen still lands in the stored data.
    always_comb begin
        ex_d = ex_q;
        unique case (upd)
            UPD_BUBBLE: begin
                ex_d = '0;
            end
            UPD_HOLD: begin
                ex_d.rs_val = fwd_rs;
                ex_d.rt_val = fwd_rt;
            end
            default: begin
                ex_d.valid     = id_valid;
                ex_d.rs        = id_rs;
                ex_d.rt        = id_rt;
                ex_d.rd        = id_rd;
                ex_d.aluc      = id_aluc;
                ex_d.sel_shamt = id_sel_shamt;
                ex_d.sel_imm   = id_sel_imm;
                ex_d.shamt     = id_shamt;
                ex_d.imm       = id_imm;
                ex_d.rs_val    = (id_rs == '0) ? '0 : id_rs_data;
                ex_d.rt_val    = (id_rt == '0) ? '0 : id_rt_data;
                ex_d.reg_write = id_reg_write & id_valid;
                ex_d.mem_read  = id_mem_read & id_valid;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    always_comb begin
        ex_valid     = ex_q.valid;
        ex_a         = ex_q.sel_shamt ? {27'b0, ex_q.shamt} : fwd_rs;
        ex_b         = ex_q.sel_imm ? ex_q.imm : fwd_rt;
        ex_aluc      = ex_q.aluc;
        ex_rd        = ex_q.rd;
        ex_reg_write = ex_q.valid & ex_q.reg_write;
        ex_mem_read  = ex_q.valid & ex_q.mem_read;
    end

endmodule
